exc_ctrl: RTL
=============

Name: exc_ctrl

Overview:
Exception/interrupt sequencer for the pipelined LEGv8 core (`processor_arm`). It watches the MEM-stage instruction for an invalid-opcode fault and the asynchronous ExtIRQ line, and picks one cause. It then flushes the pipeline, saves ELR/ESR, redirects fetch to the exception vector, and on ERET redirects back to ELR. The datapath instantiates it alongside the hazard unit. Its flush and redirect outputs override the normal PC mux.

Parameters:
N, 64, datapath/address width
EXC_VECTOR, 64'hD8, handler entry address driven on redirect
SYNC_STAGES, 2, flip-flop depth of the ExtIRQ synchroniser (min 2)

Ports:
CLOCK_50  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
ExtIRQ  in  1  external interrupt, asynchronous level, held until irq_ack_o
valid_i  in  1  MEM stage holds a real (non-bubble) instruction
invalid_op_i  in  1  MEM-stage instruction has an undefined opcode (qualified by valid_i)
eret_i  in  1  MEM-stage instruction is ERET (qualified by valid_i)
exc_pc_i  in  N  PC of the MEM-stage instruction
exc_flush_o  out  1  flush IF/ID/EX/MEM registers this cycle
pc_redirect_o  out  1  PC mux selects redirect_addr_o this cycle
redirect_addr_o  out  N  target PC: EXC_VECTOR or ELR
elr_o  out  N  exception link register
esr_o  out  4  exception syndrome: 4'b0001 ExtIRQ, 4'b0010 invalid opcode, 4'b0000 none
irq_ack_o  out  1  one-cycle pulse when an IRQ is taken
in_handler_o  out  1  handler active (interrupts masked)
double_fault_o  out  1  sticky: invalid opcode occurred while in the handler

Behaviour:
- Reset (reset=0, any time, asynchronous): state=IDLE, synchroniser flops=0, irq_pending=0, all outputs 0 including elr_o, esr_o and double_fault_o. An exception in progress is abandoned.
- ExtIRQ synchroniser:
  - ExtIRQ sampled at edge t reaches sync_out at edge t+SYNC_STAGES-1.
  - irq_pending is set on the following edge (t+2 for the default depth).
  - irq_pending is cleared only when the IRQ is taken.
- States: IDLE, FLUSH, VECTOR, HANDLER, RETURN. One transition per clock.
- IDLE transitions:
  - valid_i & invalid_op_i -> FLUSH; latch elr=exc_pc_i, esr=0010, cause=SYNC.
  - else valid_i & irq_pending -> FLUSH; latch elr=exc_pc_i (instruction not committed, re-executed after ERET), esr=0001, cause=IRQ.
  - else stay in IDLE.
  - Priority: invalid op beats IRQ on the same cycle. The IRQ stays pending and is taken after the ERET completes.
- FLUSH (1 cycle):
  - exc_flush_o=1.
  - irq_ack_o=1 iff cause=IRQ; irq_pending clears at the end of this cycle.
  - -> VECTOR.
- VECTOR (1 cycle): exc_flush_o=1, pc_redirect_o=1, redirect_addr_o=EXC_VECTOR. -> HANDLER.
- HANDLER:
  - in_handler_o=1; irq_pending may set but is not taken.
  - valid_i & eret_i -> RETURN.
  - valid_i & invalid_op_i -> double_fault_o<=1; stay in HANDLER; elr/esr unchanged.
  - eret_i and invalid_op_i together: eret wins.
- RETURN (1 cycle):
  - exc_flush_o=1, pc_redirect_o=1, redirect_addr_o=elr_o.
  - -> IDLE; esr_o<=0000; elr_o holds.
- Combinational inputs are ignored outside IDLE/HANDLER. eret_i in IDLE is ignored (no redirect).
- Outputs are Moore (registered state decode); no combinational input-to-output path.
- Entry latency: fault visible at edge k -> flush during cycle k+1 -> redirect during cycle k+2 -> first handler fetch at edge k+3.

Decomposition:
- Package exc_pkg:
  - state_t enum {IDLE, FLUSH, VECTOR, HANDLER, RETURN}
  - cause_t {SYNC, IRQ}
  - ESR_NONE/ESR_IRQ/ESR_INVOP localparams
  - default EXC_VECTOR
- Sub-module sync_ff (parameter STAGES, asynchronous active-low reset). Instantiated once for ExtIRQ.

Test Plan:
- Reset with ExtIRQ=0, then idle 10 cycles -> all outputs 0, state IDLE; assert reset mid-VECTOR -> outputs 0 in the same cycle, no redirect.
- valid_i=1, invalid_op_i=1, exc_pc_i=64'h20 at edge k -> flush at k+1; redirect 64'hD8 at k+2; elr_o=64'h20; esr_o=0010; irq_ack_o never asserts.
- ExtIRQ=1 at edge t, valid_i=1, exc_pc_i=64'h40 -> irq_pending at t+2, FLUSH at t+3 with irq_ack_o pulse; redirect 64'hD8; elr_o=64'h40; esr_o=0001.
- In HANDLER, eret_i=1 with valid_i=1 -> RETURN with redirect_addr_o=elr_o (64'h40) for exactly 1 cycle, then IDLE with esr_o=0000.
- invalid_op_i and irq_pending in the same IDLE cycle -> esr_o=0010 first; after ERET the IRQ is taken (esr_o=0001) with no extra ExtIRQ edge needed.
- invalid_op_i while in HANDLER -> double_fault_o=1 and stays 1 until reset; elr_o/esr_o unchanged; ExtIRQ pulses in HANDLER are not taken until after RETURN.

Source files
------------

// File: rtl/exc_pkg.sv
// Shared types and constants for the exception/interrupt sequencer.
// Latency: n/a (types only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, exception cause, syndrome codes and the
// default handler entry address.
package exc_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FLUSH   = 3'd1,
    VECTOR  = 3'd2,
    HANDLER = 3'd3,
    RETURN  = 3'd4
  } state_t;

  typedef enum logic {
    SYNC = 1'b0,
    IRQ  = 1'b1
  } cause_t;

  localparam logic [3:0] ESR_NONE  = 4'b0000;
  localparam logic [3:0] ESR_IRQ   = 4'b0001;
  localparam logic [3:0] ESR_INVOP = 4'b0010;

  localparam logic [63:0] EXC_VECTOR_DFLT = 64'hD8;

endpackage

// File: rtl/exc_ctrl_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level.
// Latency: an input sampled at edge t appears on q_o after edge t+STAGES-1.
// Backpressure: none.
//
// Ports: clk_i (clock), rst_ni (async active-low reset), d_i (async input),
//        q_o (synchronised output).
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else begin
      q_q <= {q_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = q_q[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: picks invalid-opcode or ExtIRQ, flushes, vectors, returns on ERET.
// Latency: fault at edge k -> flush cycle k+1 -> redirect cycle k+2 -> handler fetch at edge k+3.
// Backpressure: none; inputs are ignored outside IDLE/HANDLER and all outputs are registered.
//
// Ports: CLOCK_50/reset (clock, async active-low reset); ExtIRQ (async IRQ level);
//        valid_i/invalid_op_i/eret_i/exc_pc_i (MEM-stage instruction info);
//        exc_flush_o/pc_redirect_o/redirect_addr_o (pipeline control);
//        elr_o/esr_o (link + syndrome); irq_ack_o, in_handler_o, double_fault_o (status).
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int             N           = 64,
  parameter logic [N-1:0]   EXC_VECTOR  = N'(EXC_VECTOR_DFLT),
  parameter int             SYNC_STAGES = 2
) (
  input  logic         CLOCK_50,
  input  logic         reset,
  input  logic         ExtIRQ,
  input  logic         valid_i,
  input  logic         invalid_op_i,
  input  logic         eret_i,
  input  logic [N-1:0] exc_pc_i,
  output logic         exc_flush_o,
  output logic         pc_redirect_o,
  output logic [N-1:0] redirect_addr_o,
  output logic [N-1:0] elr_o,
  output logic [3:0]   esr_o,
  output logic         irq_ack_o,
  output logic         in_handler_o,
  output logic         double_fault_o
);

  state_t       state_q;
  cause_t       cause_q;
  logic         irq_sync;
  logic         irq_sync_last_q;
  logic         irq_pending_q;
  logic         irq_pending_d;
  logic         flush_q;
  logic         redirect_q;
  logic [N-1:0] redirect_addr_q;
  logic [N-1:0] elr_q;
  logic [3:0]   esr_q;
  logic         ack_q;
  logic         in_handler_q;
  logic         dfault_q;

  sync_ff #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk_i  (CLOCK_50),
    .rst_ni (reset),
    .d_i    (ExtIRQ),
    .q_o    (irq_sync)
  );

  // Pending is set on the synchronised rising edge rather than the level:
  // the device drops ExtIRQ only after seeing irq_ack_o, so the old level is
  // still travelling through the synchroniser after the IRQ has been taken
  // and must not re-arm the request. A new edge wins over the clear.
  assign irq_pending_d = (irq_sync & ~irq_sync_last_q) |
                         (irq_pending_q & ~((state_q == FLUSH) && (cause_q == IRQ)));

  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      irq_sync_last_q <= 1'b0;
      irq_pending_q   <= 1'b0;
    end else begin
      irq_sync_last_q <= irq_sync;
      irq_pending_q   <= irq_pending_d;
    end
  end

  // Sequencer FSM. Outputs are registered alongside the state transition so
  // each output reflects the state being entered.
  always_ff @(posedge CLOCK_50 or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      cause_q         <= SYNC;
      flush_q         <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      elr_q           <= '0;
      esr_q           <= ESR_NONE;
      ack_q           <= 1'b0;
      in_handler_q    <= 1'b0;
      dfault_q        <= 1'b0;
    end else begin
      flush_q         <= 1'b0;
      redirect_q      <= 1'b0;
      redirect_addr_q <= '0;
      ack_q           <= 1'b0;
      in_handler_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_i && invalid_op_i) begin
            state_q <= FLUSH;
            cause_q <= SYNC;
            elr_q   <= exc_pc_i;
            esr_q   <= ESR_INVOP;
            flush_q <= 1'b1;
          end else if (valid_i && irq_pending_q) begin
            // The MEM instruction has not committed; it re-executes after ERET.
            state_q <= FLUSH;
            cause_q <= IRQ;
            elr_q   <= exc_pc_i;
            esr_q   <= ESR_IRQ;
            flush_q <= 1'b1;
            ack_q   <= 1'b1;
          end
        end
        FLUSH: begin
          state_q         <= VECTOR;
          flush_q         <= 1'b1;
          redirect_q      <= 1'b1;
          redirect_addr_q <= EXC_VECTOR;
        end
        VECTOR: begin
          state_q      <= HANDLER;
          in_handler_q <= 1'b1;
        end
        HANDLER: begin
          if (valid_i && eret_i) begin
            state_q         <= RETURN;
            flush_q         <= 1'b1;
            redirect_q      <= 1'b1;
            redirect_addr_q <= elr_q;
          end else begin
            in_handler_q <= 1'b1;
            if (valid_i && invalid_op_i) begin
              dfault_q <= 1'b1;
            end
          end
        end
        RETURN: begin
          state_q <= IDLE;
          esr_q   <= ESR_NONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign exc_flush_o     = flush_q;
  assign pc_redirect_o   = redirect_q;
  assign redirect_addr_o = redirect_addr_q;
  assign elr_o           = elr_q;
  assign esr_o           = esr_q;
  assign irq_ack_o       = ack_q;
  assign in_handler_o    = in_handler_q;
  assign double_fault_o  = dfault_q;

endmodule
